motor_pwm_decoder: RTL and testbench

Recovers the signed 11-bit motor commands from the four PWM drive lines that `motor_cntrl` produces (`fwd_lft`, `rev_lft`, `fwd_rht`, `rev_rht`). Duty is measured over fixed 1024-cycle windows and the direction, brake and illegal-drive conditions are decoded. It sits on the far side of the motor interface, in motor-model benches and in on-chip loopback self-check.

---
 rtl/motor_pkg.sv | 11 +
 rtl/pwm_chan_meas.sv | 50 +++++
 rtl/motor_pwm_decoder.sv | 48 ++++
 tb/tb_motor_pwm_decoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared widths and the per-window decode classification for the motor PWM decoder.
package motor_pkg;
    localparam int PWM_W   = 10;
    localparam int CMD_W   = 11;
    localparam int MAG_MAX = 1023;
    typedef enum logic [1:0] {COAST, FWD, REV, BRK_ERR} dec_e;
    typedef enum logic [1:0] {PH_IDLE, PH_SKIP, PH_RUN} phase_e;
    function automatic dec_e decode(logic f_nz, logic r_nz);
        return (f_nz && r_nz) ? BRK_ERR : f_nz ? FWD : r_nz ? REV : COAST;
    endfunction
endpackage

// File: rtl/pwm_chan_meas.sv
// pwm_chan_meas: one motor channel; counts registered fwd/rev high cycles per window and decodes at win_end.
module pwm_chan_meas #(
    parameter int PWM_W = motor_pkg::PWM_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fwd,
    input  logic                       rev,
    input  logic                       win_end,
    input  logic                       upd,
    output logic [motor_pkg::CMD_W-1:0] meas,
    output logic                       brk,
    output logic                       err
);
    import motor_pkg::*;
    logic fwd_q, rev_q, brake;
    logic [PWM_W:0] f_cnt, r_cnt;
    logic [CMD_W-1:0] f_mag, r_mag, meas_d;
    dec_e dec;
    // a full-window count (2^PWM_W) saturates to the largest encodable magnitude
    always_comb begin
        f_mag  = {{(CMD_W-PWM_W){1'b0}}, f_cnt[PWM_W] ? {PWM_W{1'b1}} : f_cnt[PWM_W-1:0]};
        r_mag  = {{(CMD_W-PWM_W){1'b0}}, r_cnt[PWM_W] ? {PWM_W{1'b1}} : r_cnt[PWM_W-1:0]};
        dec    = decode(|f_cnt, |r_cnt);
        brake  = f_cnt[PWM_W] & r_cnt[PWM_W];
        meas_d = (dec == FWD) ? f_mag : (dec == REV) ? -r_mag : '0;
    end
    // the wrap cycle's sample starts the new window, so clear and add in one step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= 1'b0;
            rev_q <= 1'b0;
            f_cnt <= '0;
            r_cnt <= '0;
            meas  <= '0;
            brk   <= 1'b0;
            err   <= 1'b0;
        end else begin
            fwd_q <= fwd;
            rev_q <= rev;
            f_cnt <= (win_end ? '0 : f_cnt) + {{PWM_W{1'b0}}, fwd_q};
            r_cnt <= (win_end ? '0 : r_cnt) + {{PWM_W{1'b0}}, rev_q};
            if (upd) begin
                meas <= meas_d;
                brk  <= (dec == BRK_ERR) && brake;
                err  <= (dec == BRK_ERR) && !brake;
            end
        end
    end
endmodule

// File: rtl/motor_pwm_decoder.sv
// motor_pwm_decoder: recovers signed motor commands from motor_cntrl PWM lines over fixed 2^PWM_W-cycle windows.
module motor_pwm_decoder #(
    parameter int PWM_W = motor_pkg::PWM_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fwd_lft,
    input  logic                       rev_lft,
    input  logic                       fwd_rht,
    input  logic                       rev_rht,
    output logic [motor_pkg::CMD_W-1:0] lft_meas,
    output logic [motor_pkg::CMD_W-1:0] rht_meas,
    output logic                       brk_lft,
    output logic                       brk_rht,
    output logic                       err_lft,
    output logic                       err_rht,
    output logic                       meas_vld
);
    import motor_pkg::*;
    logic [PWM_W-1:0] win_cnt;
    logic win_end, upd;
    phase_e ph, ph_nxt;
    // the first window holds a reset-value input sample, so its decode is skipped
    always_comb begin
        win_end = (win_cnt == '0);
        upd     = win_end && (ph == PH_RUN);
        ph_nxt  = (ph == PH_IDLE) ? PH_SKIP : (ph == PH_SKIP && win_end) ? PH_RUN : ph;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            ph       <= PH_IDLE;
            meas_vld <= 1'b0;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            ph       <= ph_nxt;
            meas_vld <= upd;
        end
    end
    pwm_chan_meas #(.PWM_W(PWM_W)) u_lft (
        .clk(clk), .rst_n(rst_n), .fwd(fwd_lft), .rev(rev_lft), .win_end(win_end), .upd(upd),
        .meas(lft_meas), .brk(brk_lft), .err(err_lft)
    );
    pwm_chan_meas #(.PWM_W(PWM_W)) u_rht (
        .clk(clk), .rst_n(rst_n), .fwd(fwd_rht), .rev(rev_rht), .win_end(win_end), .upd(upd),
        .meas(rht_meas), .brk(brk_rht), .err(err_rht)
    );
endmodule

// File: tb/tb_motor_pwm_decoder.sv
// tb_motor_pwm_decoder: PWM source model drives the decoder; a window-sum reference feeds a scoreboard queue.
module tb_motor_pwm_decoder;
    logic clk = 1'b0, rst_n = 1'b0;
    logic fwd_lft = 1'b0, rev_lft = 1'b0, fwd_rht = 1'b0, rev_rht = 1'b0;
    logic [10:0] lft_meas, rht_meas;
    logic brk_lft, brk_rht, err_lft, err_rht, meas_vld;

    motor_pwm_decoder dut (
        .clk(clk), .rst_n(rst_n), .fwd_lft(fwd_lft), .rev_lft(rev_lft), .fwd_rht(fwd_rht),
        .rev_rht(rev_rht), .lft_meas(lft_meas), .rht_meas(rht_meas), .brk_lft(brk_lft),
        .brk_rht(brk_rht), .err_lft(err_lft), .err_rht(err_rht), .meas_vld(meas_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] res;
        int          edge_no;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, nvld = 0;
    int fd[2], rd[2];
    int ph;

    function automatic void chk(string n, longint a, longint x);
        checks++;
        if (a != x) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", n, a, x);
        end
    endfunction

    // expected result of one window from its high-cycle counts
    function automatic logic [12:0] win_dec(int f, int r);
        logic [10:0] m;
        logic b, e;
        int mag;
        m = '0; b = 1'b0; e = 1'b0;
        if (f == 1024 && r == 1024) b = 1'b1;
        else if (f > 0 && r > 0) e = 1'b1;
        else if (f > 0) m = 11'((f > 1023) ? 1023 : f);
        else if (r > 0) begin
            mag = (r > 1023) ? 1023 : r;
            m = 11'(-mag);
        end
        return {m, b, e};
    endfunction

    // motor_cntrl-style encoder: 0 is brake, positive drives fwd, negative drives rev
    task automatic set_cmd(int side, logic [10:0] c);
        int mag;
        if (c == 11'h000) begin
            fd[side] = 1024; rd[side] = 1024;
        end else if (!c[10]) begin
            fd[side] = int'(c); rd[side] = 0;
        end else begin
            mag = 2048 - int'(c);
            fd[side] = 0; rd[side] = (mag > 1023) ? 1023 : mag;
        end
    endtask

    always @(negedge clk) begin
        ph = (ph + 1) % 1024;
        fwd_lft = ph < fd[0];
        rev_lft = ph < rd[0];
        fwd_rht = ph < fd[1];
        rev_rht = ph < rd[1];
    end

    // reference: edge e captures the lines; captures e%1024 = 0..1023 form one window, reported at edge +2
    int e_no, fl, rl, fr, rr;
    always @(posedge clk) begin
        if (!rst_n) begin
            e_no = 0; fl = 0; rl = 0; fr = 0; rr = 0;
            q.delete();
        end else begin
            e_no++;
            fl += int'(fwd_lft); rl += int'(rev_lft);
            fr += int'(fwd_rht); rr += int'(rev_rht);
            if (e_no % 1024 == 1023) begin
                if (e_no > 1023) begin
                    logic [12:0] a, b;
                    a = win_dec(fl, rl);
                    b = win_dec(fr, rr);
                    q.push_back('{res: {a[12:2], b[12:2], a[1], b[1], a[0], b[0]}, edge_no: e_no + 2});
                end
                fl = 0; rl = 0; fr = 0; rr = 0;
            end
        end
    end

    exp_t x;
    always @(negedge clk) begin
        if (rst_n && meas_vld) begin
            nvld++;
            if (q.size() == 0) chk("vld_unexpected", 1, 0);
            else begin
                x = q.pop_front();
                chk("vld_edge", e_no, x.edge_no);
                chk("window", {lft_meas, rht_meas, brk_lft, brk_rht, err_lft, err_rht}, x.res);
            end
        end
    end

    task automatic wait_vld(int n);
        int target, t;
        target = nvld + n;
        t = 0;
        while (nvld < target && t < 3000 * n) begin
            @(negedge clk);
            t++;
        end
        if (nvld < target) chk("vld_timeout", nvld, target);
        @(negedge clk);
    endtask

    task automatic run_cmd(logic [10:0] l, logic [10:0] r, int n);
        set_cmd(0, l);
        set_cmd(1, r);
        wait_vld(n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=0 want=1");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] v;
        int c;
        ph = $urandom_range(0, 1023);
        fd = '{0, 0}; rd = '{0, 0};
        set_cmd(0, 11'h100);
        set_cmd(1, 11'h100);
        repeat (3) @(negedge clk);
        chk("reset_outs", {lft_meas, rht_meas, brk_lft, brk_rht, err_lft, err_rht, meas_vld}, 0);
        rst_n = 1'b1;
        wait_vld(3);
        chk("fwd_100", {lft_meas, rht_meas, brk_lft, brk_rht, err_lft, err_rht}, {11'h100, 11'h100, 4'b0});
        run_cmd(11'h700, 11'h400, 3);
        chk("rev_clamp", {lft_meas, rht_meas, brk_lft, brk_rht, err_lft, err_rht}, {11'h700, 11'h401, 4'b0});
        run_cmd(11'h000, 11'h000, 3);
        chk("brake", {lft_meas, rht_meas, brk_lft, brk_rht, err_lft, err_rht}, {22'h0, 4'b1100});
        fd[0] = 512; rd[0] = 512;
        set_cmd(1, 11'h3FF);
        wait_vld(3);
        chk("err_lft", {lft_meas, rht_meas, brk_lft, brk_rht, err_lft, err_rht}, {11'h0, 11'h3FF, 4'b0010});
        fd[0] = 300; rd[0] = 0;
        set_cmd(1, 11'h401);
        wait_vld(3);
        chk("duty_300", {lft_meas, rht_meas, brk_lft, brk_rht, err_lft, err_rht}, {11'h12C, 11'h401, 4'b0});
        for (int i = 0; i < 4; i++) run_cmd(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 2);
        run_cmd(11'h100, 11'h100, 2);
        repeat (500) @(negedge clk);
        set_cmd(0, 11'h080);
        wait_vld(1);
        v = lft_meas;
        chk("blend_range", (v >= 11'h080 && v <= 11'h100) ? 1 : 0, 1);
        wait_vld(1);
        chk("blend_settle", lft_meas, 11'h080);
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_clear", {lft_meas, rht_meas, brk_lft, brk_rht, err_lft, err_rht, meas_vld}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (c < 3000) begin
            @(posedge clk);
            c++;
            #1;
            if (meas_vld) break;
        end
        chk("first_vld_edge", c, 2049);
        repeat (5) @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
